// File: rtl/debug_apb_master_pkg.sv
// rtl/debug_apb_master_pkg.sv - shared types and address map for the debug APB master
//
// Purpose: FSM state encoding of debug_apb_master and the debug register
// block address map, shared by the RTL and the bench.
// Ports: none (package).

package debug_apb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [31:0] DEBUG_APB_BASE = 32'h4000_0000;
  localparam logic [7:0]  DREG0_OFF      = 8'h00;
  localparam logic [7:0]  DREG1_OFF      = 8'h04;
  localparam logic [7:0]  DREG2_OFF      = 8'h08;
  localparam logic [7:0]  DREG3_OFF      = 8'h0C;

endpackage

// File: rtl/debug_apb_master.sv
// rtl/debug_apb_master.sv - single-transfer APB initiator behind a valid/ready command port
//
// Purpose: accepts one command at a time, runs an APB SETUP/ACCESS transfer
// with pready wait states and an optional wait-state timeout, and returns
// the result on a valid/ready response port.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   cmd_valid/ready/write/addr/wdata command request port
//   rsp_valid/ready/rdata/err        response port (err = pslverr or timeout)
//   psel/penable/pwrite/paddr/pwdata APB request outputs
//   prdata/pready/pslverr            APB responder inputs

module debug_apb_master
  import debug_apb_master_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // Counter holds 0..TIMEOUT-1; one bit minimum so a disabled timeout still elaborates.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state_q,     state_d;
  logic              psel_q,      psel_d;
  logic              penable_q,   penable_d;
  logic              pwrite_q,    pwrite_d;
  logic [ADDR_W-1:0] paddr_q,     paddr_d;
  logic [DATA_W-1:0] pwdata_q,    pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  assign cmd_ready = (state_q == ST_IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        // cmd_ready is high in IDLE, so cmd_valid alone is the handshake.
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pwrite_d = cmd_write;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pready is checked first so a completion beats a same-cycle timeout.
        if (pready) begin
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_debug_apb_master.sv
// tb/tb_debug_apb_master.sv - randomized self-checking bench for debug_apb_master

module tb_debug_apb_master;
  import debug_apb_master_pkg::*;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debug_apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // Stand-in debug register block: combinational read on paddr, write in ACCESS.
  logic [31:0] blk_regs [4];
  int          cur_waits = 0;
  logic        cur_err   = 1'b0;
  int          acc_cyc   = 0;

  function automatic bit dreg_hit(input logic [31:0] a);
    return (a[31:4] == DEBUG_APB_BASE[31:4]) && (a[1:0] == 2'b00);
  endfunction

  always_comb begin
    prdata = dreg_hit(paddr) ? blk_regs[paddr[3:2]] : 32'h0;
  end
  assign pready  = (acc_cyc >= cur_waits);
  assign pslverr = cur_err;

  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cyc <= acc_cyc + 1;
    else                            acc_cyc <= 0;
    if (psel && penable && pready && pwrite && dreg_hit(paddr))
      blk_regs[paddr[3:2]] <= pwdata;
  end

  // Reference model: register contents as the specification says they should be.
  logic [31:0] mdl_regs [4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int waits, input logic err, input int hold);
    bit          abort;
    int          exp_acc, acc;
    logic        exp_err;
    logic [31:0] exp_rd;
    abort   = (TIMEOUT != 0) && (waits >= TIMEOUT);
    exp_acc = abort ? TIMEOUT : waits + 1;
    exp_err = abort ? 1'b1 : err;
    exp_rd  = (abort || wr) ? 32'h0 : (dreg_hit(addr) ? mdl_regs[addr[3:2]] : 32'h0);
    if (!abort && wr && dreg_hit(addr)) mdl_regs[addr[3:2]] = wd;

    @(negedge clk);
    cur_waits = waits;
    cur_err   = err;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = ~wr;
    chk("setup_psel_penable", {psel, penable}, 2'b10);
    chk("setup_cmd_ready", cmd_ready, 0);
    chk("setup_paddr", paddr, addr);
    chk("setup_pwrite", pwrite, wr);
    chk("setup_pwdata", pwdata, wd);

    acc = 0;
    forever begin
      @(posedge clk); #1;
      if (!(psel && penable) || acc > 300) break;
      acc++;
      chk("access_stable", {pwrite, paddr, pwdata}, {wr, addr, wd});
    end
    chk("access_cycles", acc, exp_acc);
    chk("done_psel", {psel, penable}, 2'b00);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_rdata", rsp_rdata, exp_rd);

    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, exp_err, exp_rd});
      chk("hold_busy", {cmd_ready, psel}, 2'b00);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_done", {rsp_valid, cmd_ready, psel}, 3'b010);
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      blk_regs[i] = 32'h0;
      mdl_regs[i] = 32'h0;
    end
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {psel, penable, pwrite, paddr, pwdata}, 67'h0);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
    chk("reset_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: write, readback, unmapped read, wait states, timeout, pslverr.
    do_txn(1'b1, DEBUG_APB_BASE + 32'(DREG1_OFF), 32'hDEADBEEF, 0, 1'b0, 0);
    chk("dreg1_written", blk_regs[1], 32'hDEADBEEF);
    do_txn(1'b0, DEBUG_APB_BASE + 32'(DREG1_OFF), 32'h0, 0, 1'b0, 0);
    do_txn(1'b0, DEBUG_APB_BASE + 32'h10, 32'h0, 0, 1'b0, 0);
    do_txn(1'b1, DEBUG_APB_BASE + 32'(DREG2_OFF), 32'h12345678, 0, 1'b0, 0);
    do_txn(1'b0, DEBUG_APB_BASE + 32'(DREG2_OFF), 32'h0, 3, 1'b0, 0);
    do_txn(1'b0, DEBUG_APB_BASE + 32'(DREG2_OFF), 32'h0, 10, 1'b0, 0);
    do_txn(1'b1, DEBUG_APB_BASE + 32'(DREG0_OFF), 32'h55AA55AA, 4, 1'b0, 0);
    do_txn(1'b0, DEBUG_APB_BASE + 32'(DREG2_OFF), 32'h0, 3, 1'b0, 1);
    do_txn(1'b1, DEBUG_APB_BASE + 32'(DREG3_OFF), 32'hCAFEF00D, 0, 1'b1, 5);

    // Reset during ACCESS: the pending transfer is dropped without a response.
    @(negedge clk);
    cur_waits = 20; cur_err = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = DEBUG_APB_BASE; cmd_wdata = 32'h0BAD0BAD;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_access", {psel, penable}, 2'b11);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_reset_apb", {psel, penable, rsp_valid}, 3'b000);
    chk("mid_reset_idle", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_no_rsp", {rsp_valid, psel}, 2'b00);
    do_txn(1'b1, DEBUG_APB_BASE + 32'(DREG3_OFF), 32'h1, 0, 1'b0, 0);
    chk("dreg0_kept", blk_regs[0], mdl_regs[0]);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0:       a = $urandom;
        1:       a = DEBUG_APB_BASE + 32'h10;
        default: a = DEBUG_APB_BASE + 32'($urandom_range(0, 3) * 4);
      endcase
      do_txn(1'($urandom), a, $urandom, $urandom_range(0, 6),
             ($urandom_range(0, 5) == 0), $urandom_range(0, 3));
    end
    for (int i = 0; i < 4; i++) chk("final_regs", blk_regs[i], mdl_regs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
